spi_slave_ctrl: RTL



---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_edge_sync.sv | 31 +++
 rtl/spi_slave_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI slave controller
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_SS = 2'd2
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cphase;
    } spi_mode_t;

    localparam int SPI_MIN_OVERSAMPLE = 8;

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - multi-flop input synchronizer with rise/fall pulse outputs
module spi_edge_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - oversampling SPI slave with rx deserializer and one-entry tx buffer; SPI_SLAVE_FRAME_ERR_EN adds frame_err
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_POLARITY = 0,
    parameter int CLK_PHASE    = 0,
    parameter int DATA_WIDTH   = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    input  logic                  ss,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_underrun
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic                  frame_err
`endif
);

    localparam spi_mode_t MODE = '{cpol: (CLK_POLARITY != 0), cphase: (CLK_PHASE != 0)};
    localparam int        CW   = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    spi_state_t state, next_state;

    logic sclk_sync, sclk_rise, sclk_fall;
    logic ss_sync, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic mosi_sync;
    logic sclk_edge, leading, trailing, sample_edge, change_edge;
    logic start, do_sample, finish;

    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] rx_sr, tx_sr, tx_buf, tx_src;
    logic                  tx_full;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(MODE.cpol)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .dout(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
    );

    // ss resets as "asserted" so a frame already in progress at reset release is never joined
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_ss_sync (
        .clk(clk), .rst_n(rst_n), .din(ss),
        .dout(ss_sync), .rise(ss_rise), .fall(ss_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mosi_q <= '0;
        else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_sync = mosi_q[SYNC_STAGES-1];

    assign sclk_edge   = sclk_rise | sclk_fall;
    assign leading     = sclk_edge & (sclk_sync != MODE.cpol);
    assign trailing    = sclk_edge & (sclk_sync == MODE.cpol);
    assign sample_edge = MODE.cphase ? trailing : leading;
    assign change_edge = MODE.cphase ? leading : trailing;

    assign tx_src   = tx_full ? tx_buf : '0;
    assign tx_ready = ~tx_full;
    assign busy     = (state != IDLE);

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic frame_fault;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        do_sample  = 1'b0;
        finish     = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        frame_fault = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    next_state = SHIFT;
                    start      = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    next_state = IDLE;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                    frame_fault = 1'b1;
`endif
                end else if (sample_edge) begin
                    do_sample = 1'b1;
                    if (cnt == LAST) begin
                        finish     = 1'b1;
                        next_state = WAIT_SS;
                    end
                end
            end
            WAIT_SS: begin
                if (ss_sync) begin
                    next_state = IDLE;
                end
`ifdef SPI_SLAVE_FRAME_ERR_EN
                else if (sample_edge) begin
                    frame_fault = 1'b1;
                end
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            miso        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            if (start) begin
                cnt         <= '0;
                rx_sr       <= '0;
                tx_underrun <= ~tx_full;
                // CPHA=0 presents the MSB immediately; CPHA=1 waits for the first leading edge
                if (MODE.cphase) begin
                    tx_sr <= tx_src;
                    miso  <= 1'b0;
                end else begin
                    tx_sr <= {tx_src[DATA_WIDTH-2:0], 1'b0};
                    miso  <= tx_src[DATA_WIDTH-1];
                end
            end else if (state == SHIFT && next_state == SHIFT) begin
                if (do_sample) begin
                    rx_sr <= {rx_sr[DATA_WIDTH-2:0], mosi_sync};
                    cnt   <= cnt + CW'(1);
                end
                if (change_edge) begin
                    miso  <= tx_sr[DATA_WIDTH-1];
                    tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                end
            end else begin
                miso <= 1'b0;
            end
            if (finish) begin
                rx_data  <= {rx_sr[DATA_WIDTH-2:0], mosi_sync};
                rx_valid <= 1'b1;
                cnt      <= cnt + CW'(1);
            end
            if (start && tx_full) begin
                tx_full <= 1'b0;
            end else if (tx_valid && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_err <= 1'b0;
        else        frame_err <= frame_fault;
    end
`endif

endmodule
